// File: rtl/fib_result_reader.sv
// ---------------------------------------------------------------------------
// fib_result_reader
//
// Host-side consumer of the Fibonacci-sum result table. After a start pulse
// it waits for the producer to flag the table valid (rReady). It then reads
// addresses 0..DEPTH-1 one at a time. After each address it waits RD_LAT
// cycles for the read latency before it samples rDout. Each word is compared
// against an internally generated sequence: SEED0, SEED1, then sums of the
// previous two words mod 2^ALU_W, zero-extended to DATA_W. The block reports
// done/pass, whether the sweep was aborted, the mismatch count and the first
// failing address.
//
// Parameters:
//   DEPTH   words swept, 3..64 (addresses 0..DEPTH-1)
//   DATA_W  width of rDout (must be >= ALU_W)
//   ALU_W   width of the producer's adder; expected sums wrap at 2^ALU_W
//   RD_LAT  cycles from rAddr driven to rDout valid, >= 1
//   SEED0   expected word at address 0
//   SEED1   expected word at address 1
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   start           one-cycle pulse, honoured only when idle or done
//   rReady          producer result-table-valid flag
//   rAddr           read address to the producer
//   rDout           read data from the producer
//   busy            high from the accepted start until done
//   done            high once the sweep has finished, held until next start
//   pass            valid with done: every word matched and no abort
//   aborted         valid with done: rReady fell while waiting for data
//   err_count       mismatches in the current/last sweep (0..DEPTH)
//   first_err_addr  address of the first mismatch, 0 if none
//
// Optional feature (compile-time macro):
//   FIB_READER_STOP_ON_ERR_EN  when defined, the first mismatch ends the
//                              sweep immediately with pass=0, err_count=1.
//                              When undefined, every word is always checked.
// ---------------------------------------------------------------------------
module fib_result_reader #(
    parameter int              DEPTH  = 64,
    parameter int              DATA_W = 64,
    parameter int              ALU_W  = 32,
    parameter int              RD_LAT = 2,
    parameter logic [ALU_W-1:0] SEED0 = ALU_W'(1),
    parameter logic [ALU_W-1:0] SEED1 = ALU_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rReady,
    output logic [5:0]        rAddr,
    input  logic [DATA_W-1:0] rDout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              aborted,
    output logic [6:0]        err_count,
    output logic [5:0]        first_err_addr
);

    // The settle counter must be able to hold RD_LAT.
    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SETTLE,
        CHECK,
        DONE
    } ReaderState;

    ReaderState state;
    ReaderState stateNext;

    logic [5:0]        idx;
    logic [5:0]        idxNext;
    logic [ALU_W-1:0]  expPrev2;
    logic [ALU_W-1:0]  expPrev2Next;
    logic [ALU_W-1:0]  expPrev1;
    logic [ALU_W-1:0]  expPrev1Next;
    logic [CNT_W-1:0]  settleCnt;
    logic [CNT_W-1:0]  settleCntNext;
    logic [5:0]        rAddrNext;
    logic              passNext;
    logic              abortedNext;
    logic [6:0]        errCountNext;
    logic [5:0]        firstErrNext;
    logic [DATA_W-1:0] expWide;
    logic              wordMatch;

    // State and datapath registers. Reset wins over everything, including a
    // start pulse in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            expPrev2       <= '0;
            expPrev1       <= '0;
            settleCnt      <= '0;
            rAddr          <= '0;
            pass           <= 1'b0;
            aborted        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state          <= stateNext;
            idx            <= idxNext;
            expPrev2       <= expPrev2Next;
            expPrev1       <= expPrev1Next;
            settleCnt      <= settleCntNext;
            rAddr          <= rAddrNext;
            pass           <= passNext;
            aborted        <= abortedNext;
            err_count      <= errCountNext;
            first_err_addr <= firstErrNext;
        end
    end

    // Next-state and next-datapath logic. Every register holds its value
    // unless a state explicitly updates it. expPrev2 always holds the
    // expected word for the current idx, and expPrev1 holds the word after
    // it. Advancing one address therefore shifts the pair and adds the two
    // words. The wrap at 2^ALU_W falls out of the register width.
    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        expPrev2Next  = expPrev2;
        expPrev1Next  = expPrev1;
        settleCntNext = settleCnt;
        rAddrNext     = rAddr;
        passNext      = pass;
        abortedNext   = aborted;
        errCountNext  = err_count;
        firstErrNext  = first_err_addr;

        expWide              = '0;
        expWide[ALU_W-1:0]   = expPrev2;
        wordMatch            = (rDout == expWide);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext    = WAIT_RDY;
                    idxNext      = '0;
                    expPrev2Next = SEED0;
                    expPrev1Next = SEED1;
                    passNext     = 1'b0;
                    abortedNext  = 1'b0;
                    errCountNext = '0;
                    firstErrNext = '0;
                end
            end

            WAIT_RDY: begin
                if (rReady) begin
                    rAddrNext     = idx;
                    settleCntNext = CNT_LOAD;
                    stateNext     = SETTLE;
                end
            end

            // rAddr is held here while the producer's read pipeline fills.
            // Losing rReady makes the table untrustworthy, so the sweep ends.
            SETTLE: begin
                if (!rReady) begin
                    stateNext   = DONE;
                    abortedNext = 1'b1;
                    passNext    = 1'b0;
                end else begin
                    settleCntNext = settleCnt - 1'b1;
                    if (settleCntNext == '0) begin
                        stateNext = CHECK;
                    end
                end
            end

            CHECK: begin
                if (!wordMatch) begin
                    errCountNext = err_count + 7'd1;
                    if (err_count == 7'd0) begin
                        firstErrNext = idx;
                    end
                end
`ifdef FIB_READER_STOP_ON_ERR_EN
                if (!wordMatch) begin
                    stateNext = DONE;
                    passNext  = 1'b0;
                end else
`endif
                if (idx == LAST_IDX) begin
                    stateNext = DONE;
                    passNext  = (errCountNext == 7'd0);
                end else begin
                    idxNext       = idx + 6'd1;
                    rAddrNext     = idx + 6'd1;
                    expPrev2Next  = expPrev1;
                    expPrev1Next  = expPrev1 + expPrev2;
                    settleCntNext = CNT_LOAD;
                    stateNext     = SETTLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The status flags follow the state directly.
    always_comb begin
        busy = (state == WAIT_RDY) || (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_fib_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fib_result_reader
//
// Self-checking bench for fib_result_reader. The bench models a producer
// with an RD_LAT-deep read pipeline, so an early sample returns stale data.
// The bench builds the expected Fibonacci table with plain modular
// arithmetic. Each scenario computes the required status from the table
// contents and compares it with what the reader reports.
// Honours FIB_READER_STOP_ON_ERR_EN when compiled with the same define.
// ---------------------------------------------------------------------------
module tb_fib_result_reader;

    localparam int DEPTH        = 64;
    localparam int DATA_W       = 64;
    localparam int ALU_W        = 32;
    localparam int RD_LAT       = 2;
    localparam int SWEEP_CYCLES = DEPTH * (RD_LAT + 1) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rReady;
    logic [5:0]        rAddr;
    logic [DATA_W-1:0] rDout;
    logic              busy;
    logic              done;
    logic              pass;
    logic              aborted;
    logic [6:0]        err_count;
    logic [5:0]        first_err_addr;
    logic [16:0]       status;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] pipe    [RD_LAT];
    logic [DATA_W-1:0] expWord [DEPTH];

    fib_result_reader #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ALU_W (ALU_W),
        .RD_LAT(RD_LAT),
        .SEED0 (32'd1),
        .SEED1 (32'd1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rReady        (rReady),
        .rAddr         (rAddr),
        .rDout         (rDout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .aborted       (aborted),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // Producer model: rDout shows mem[rAddr] exactly RD_LAT cycles after
    // rAddr changes. Before that, it shows data for the previous address.
    always @(posedge clk) begin
        pipe[0] <= mem[rAddr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rDout  = pipe[RD_LAT-1];
    assign status = {busy, done, pass, aborted, err_count, first_err_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int n, output bit timedOut);
        n = 0;
        timedOut = 1'b1;
        while (n < limit) begin
            tick();
            n++;
            if (done === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    function automatic void buildExpected();
        longint unsigned modulus;
        modulus = 64'd1 << ALU_W;
        expWord[0] = 64'd1;
        expWord[1] = 64'd1;
        for (int i = 2; i < DEPTH; i++)
            expWord[i] = (longint'(expWord[i-1]) + longint'(expWord[i-2])) % modulus;
    endfunction

    function automatic void loadCorrect();
        for (int i = 0; i < DEPTH; i++) mem[i] = expWord[i];
    endfunction

    // The reference outcome depends only on which table words differ from
    // the expected sequence.
    function automatic void modelOutcome(output int errs, output int first, output int cycles);
        errs  = 0;
        first = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== expWord[i]) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        cycles = SWEEP_CYCLES;
`ifdef FIB_READER_STOP_ON_ERR_EN
        if (errs > 0) begin
            errs   = 1;
            cycles = (first + 1) * (RD_LAT + 1) + 1;
        end
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        rReady = 1'b1;
        tick();
        tick();
        checks++;
        if (status !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", status, 17'd0);
        end
        checks++;
        if (rAddr !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_rAddr: got %0d expected 0", rAddr);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_start_ignored: got busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_clean_sweep();
        int n;
        bit to;
        loadCorrect();
        rReady = 1'b1;
        pulseStart();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL clean_busy: got busy/done %b expected 10", {busy, done});
        end
        waitDone(SWEEP_CYCLES + 20, n, to);
        checks++;
        if (to || n != SWEEP_CYCLES) begin
            errors++;
            $display("[TB] FAIL clean_latency: got %0d cycles (timeout %0d) expected %0d", n, to, SWEEP_CYCLES);
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL clean_status: got %h expected %h", status, {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0});
        end
        repeat (3) tick();
        checks++;
        if (status !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0} || rAddr !== 6'(DEPTH - 1)) begin
            errors++;
            $display("[TB] FAIL clean_hold: got status %h rAddr %0d expected %h rAddr %0d",
                     status, rAddr, {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0}, DEPTH - 1);
        end
    endtask

    task automatic test_two_errors();
        int n;
        bit to;
        int expErrs;
        int expCycles;
        loadCorrect();
        mem[20] = 64'd0;
        mem[30] = 64'd1;
`ifdef FIB_READER_STOP_ON_ERR_EN
        expErrs   = 1;
        expCycles = 21 * (RD_LAT + 1) + 1;
`else
        expErrs   = 2;
        expCycles = SWEEP_CYCLES;
`endif
        pulseStart();
        waitDone(SWEEP_CYCLES + 20, n, to);
        checks++;
        if (to || n != expCycles) begin
            errors++;
            $display("[TB] FAIL two_err_latency: got %0d cycles (timeout %0d) expected %0d", n, to, expCycles);
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 7'(expErrs), 6'd20}) begin
            errors++;
            $display("[TB] FAIL two_err_status: got %h expected %h", status, {1'b0, 1'b1, 1'b0, 1'b0, 7'(expErrs), 6'd20});
        end
    endtask

    task automatic test_random_errors();
        int n;
        bit to;
        int errs;
        int first;
        int cycles;
        int a;
        for (int iter = 0; iter < 8; iter++) begin
            loadCorrect();
            repeat ($urandom_range(0, 4)) begin
                a = $urandom_range(0, DEPTH - 1);
                case ($urandom_range(0, 2))
                    0: mem[a] = {$urandom, $urandom};
                    1: mem[a] = mem[a] ^ (64'd1 << $urandom_range(ALU_W, DATA_W - 1));
                    default: mem[a] = mem[a] ^ (64'd1 << $urandom_range(0, ALU_W - 1));
                endcase
                if (mem[a] === expWord[a]) mem[a] = mem[a] ^ 64'd1;
            end
            modelOutcome(errs, first, cycles);
            pulseStart();
            waitDone(SWEEP_CYCLES + 20, n, to);
            checks++;
            if (to || n != cycles) begin
                errors++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d cycles (timeout %0d) expected %0d", iter, n, to, cycles);
            end
            checks++;
            if (status !== {1'b0, 1'b1, (errs == 0), 1'b0, 7'(errs), 6'(first)}) begin
                errors++;
                $display("[TB] FAIL rand_status[%0d]: got %h expected %h", iter, status,
                         {1'b0, 1'b1, (errs == 0), 1'b0, 7'(errs), 6'(first)});
            end
        end
    endtask

    task automatic test_late_ready();
        int n;
        bit to;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        loadCorrect();
        rReady = 1'b0;
        pulseStart();
        bad = 0;
        repeat (50) begin
            tick();
            if (rAddr !== 6'd0 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL late_ready_wait: got %0d bad cycles expected 0", bad);
        end
        rReady = 1'b1;
        waitDone(SWEEP_CYCLES + 20, n, to);
        checks++;
        if (to || n != DEPTH * (RD_LAT + 1) + 1) begin
            errors++;
            $display("[TB] FAIL late_ready_latency: got %0d cycles (timeout %0d) expected %0d", n, to, DEPTH * (RD_LAT + 1) + 1);
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL late_ready_status: got %h expected %h", status, {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0});
        end
    endtask

    task automatic test_abort();
        bit found;
        loadCorrect();
        rReady = 1'b1;
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < SWEEP_CYCLES && !found; i++) begin
            tick();
            if (rAddr === 6'd15) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL abort_reach15: got rAddr %0d expected 15", rAddr);
        end
        rReady = 1'b0;
        tick();
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL abort_status: got %h expected %h", status, {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 6'd0});
        end
        rReady = 1'b1;
        repeat (4) tick();
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL abort_hold: got %h expected %h", status, {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 6'd0});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit to;
        bit found;
        loadCorrect();
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < SWEEP_CYCLES && !found; i++) begin
            tick();
            if (rAddr === 6'd40) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rstmid_reach40: got rAddr %0d expected 40", rAddr);
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if ({status, rAddr} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_status: got %h expected 0", {status, rAddr});
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rstmid_idle: got busy/done %b expected 00", {busy, done});
        end
        pulseStart();
        waitDone(SWEEP_CYCLES + 20, n, to);
        checks++;
        if (to || n != SWEEP_CYCLES || status !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL rstmid_resweep: got %0d cycles status %h expected %0d cycles status %h",
                     n, status, SWEEP_CYCLES, {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        int errs;
        int first;
        int cycles;
        loadCorrect();
        mem[5] = mem[5] ^ 64'h0000_0001_0000_0000;
        modelOutcome(errs, first, cycles);
        pulseStart();
        n = 0;
        to = 1'b1;
        while (n < SWEEP_CYCLES + 20) begin
            start = ($urandom_range(0, 3) == 0);
            tick();
            n++;
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (to || n != cycles) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d cycles (timeout %0d) expected %0d", n, to, cycles);
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 7'(errs), 6'(first)}) begin
            errors++;
            $display("[TB] FAIL b2b_status: got %h expected %h", status, {1'b0, 1'b1, 1'b0, 1'b0, 7'(errs), 6'(first)});
        end
        loadCorrect();
        pulseStart();
        checks++;
        if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_clear: got %h expected %h", status, {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0});
        end
        waitDone(SWEEP_CYCLES + 20, n, to);
        checks++;
        if (to || n != SWEEP_CYCLES || status !== {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %0d cycles status %h expected %0d cycles status %h",
                     n, status, SWEEP_CYCLES, {1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 6'd0});
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rReady = 1'b0;
        buildExpected();
        loadCorrect();
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        test_reset();
        test_clean_sweep();
        test_two_errors();
        test_late_ready();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
